dtree_channel_scheduler: RTL and testbench
==========================================

DTREE_CHANNEL_SCHEDULER -- requirements
Module: dtree_channel_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of requesting sample channels (>=2).
REQ-002 SHALL have parameter FEATURES, default 3, features per request and per tree evaluation.
REQ-003 SHALL have parameter IN_WIDTH, default 10, signed feature width.
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles to wait for a datapath result after feeding.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, CHANNELS, per-channel request valid.
REQ-008 SHALL have port req_ready, output, CHANNELS, per-channel accept strobe.
REQ-009 SHALL have port req_features, input, CHANNELS*FEATURES*IN_WIDTH, flattened feature vectors; channel c feature k at bits [(c*FEATURES+k)*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have port dt_sample, output, IN_WIDTH, feature driven to the shared tree datapath.
REQ-011 SHALL have port dt_run, output, 1, high while dt_sample carries a valid feature.
REQ-012 SHALL have ports dt_level and dt_path, input, $clog2(FEATURES) each, plus dt_out_valid, input, 1, the datapath result.
REQ-013 SHALL have ports res_valid, output, 1; res_ready, input, 1; res_channel, output, $clog2(CHANNELS); res_level and res_path, output, $clog2(FEATURES); res_timeout, output, 1.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FEED, WAIT, HOLD.
REQ-016 In IDLE, when any req_valid is high, SHALL assert exactly one req_ready bit (combinationally), for the round-robin winner: the first valid channel after last_grant, wrapping CHANNELS-1 to 0.
REQ-017 A transfer SHALL occur when req_valid[c] and req_ready[c] are both high; the block SHALL then latch channel c's FEATURES features and c, and go to FEED.
REQ-018 req_ready SHALL be all-zero in FEED, WAIT and HOLD.
REQ-019 In FEED, SHALL drive dt_run=1 and dt_sample=feature k on the k-th FEED cycle, k=0..FEATURES-1, then go to WAIT.
REQ-020 dt_out_valid in FEED SHALL mean an early leaf: capture dt_level/dt_path, deassert dt_run from the next cycle, skip WAIT, go to HOLD.
REQ-021 In WAIT, dt_run SHALL be 0 and dt_sample SHALL hold its last value; a cycle counter SHALL start at 0 on entry.
REQ-022 dt_out_valid in WAIT SHALL capture dt_level/dt_path with res_timeout=0 and go to HOLD.
REQ-023 If TIMEOUT WAIT cycles elapse without dt_out_valid, SHALL go to HOLD with res_level=0, res_path=0, res_timeout=1.
REQ-024 In HOLD, res_valid SHALL be 1 and res_channel/res_level/res_path/res_timeout SHALL be stable until res_valid&&res_ready.
REQ-025 On that handshake, SHALL set last_grant to the served channel and go to IDLE; a new grant is possible in the following cycle.
REQ-026 dt_out_valid in IDLE or HOLD SHALL be ignored.
REQ-027 Minimum latency, accept to res_valid, SHALL be FEATURES+1 cycles when dt_out_valid arrives in the cycle after the last feature.
REQ-028 Outside FEED, dt_run SHALL be 0 and res_valid SHALL be 0 outside HOLD.

Reset
REQ-029 While reset is high, SHALL force state IDLE, last_grant=CHANNELS-1 (channel 0 has first priority), dt_run=0, dt_sample=0, res_valid=0, res_channel=0, res_level=0, res_path=0, res_timeout=0, busy=0, all counters 0.
REQ-030 Reset asserted mid-FEED, mid-WAIT or in HOLD SHALL abandon the request and drop the result without any further handshake.

Structure
REQ-031 State encoding and the default values of FEATURES, IN_WIDTH and CHANNELS SHALL live in the shared package dtree_pkg.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector and last_grant; output: one-hot grant).

Verification
REQ-033 After reset, set req_valid=4'b1111 -> channels granted in order 0,1,2,3,0; each res_channel matches.
REQ-034 Set req_valid=4'b0100 with features 10,-5,3 and return dt_out_valid one cycle after the last feature with level=2, path=1 -> dt_sample sequence 10,-5,3; res_valid 4 cycles after accept; res_channel=2, level=2, path=1.
REQ-035 Return dt_out_valid on the 2nd FEED cycle -> dt_run=0 from the 3rd cycle; result captured; no WAIT state entered.
REQ-036 Never assert dt_out_valid -> res_valid after TIMEOUT=16 WAIT cycles with res_timeout=1, level=0, path=0.
REQ-037 Hold res_ready=0 for 5 cycles -> outputs stable, req_ready=0 throughout, and no new grant until the handshake.
REQ-038 Assert reset in WAIT -> immediately IDLE, busy=0; the next grant goes to channel 0.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree channel scheduler: FSM encoding and default sizes.
package dtree_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_FEATURES = 3;
  localparam int DEF_IN_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/dtree_channel_scheduler_rr_arbiter.sv
// Round-robin grant: the first requester after last_grant wins, wrapping from N-1 to 0.
// Purely combinational, zero latency; no backpressure (the caller decides when a grant is consumed).
module rr_arbiter
  import dtree_pkg::*;
#(
  parameter int N = DEF_CHANNELS
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtree_channel_scheduler.sv
// Shares one tree datapath among CHANNELS requesters; accept-to-result is FEATURES+1 cycles minimum.
// One request in flight: req_ready is only offered in IDLE, and the result is held until res_ready.
module dtree_channel_scheduler
  import dtree_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FEATURES = DEF_FEATURES,
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int TIMEOUT  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  req_valid,
  output logic [CHANNELS-1:0]                  req_ready,
  input  logic [CHANNELS*FEATURES*IN_WIDTH-1:0] req_features,
  output logic [IN_WIDTH-1:0]                  dt_sample,
  output logic                                 dt_run,
  input  logic [$clog2(FEATURES)-1:0]          dt_level,
  input  logic [$clog2(FEATURES)-1:0]          dt_path,
  input  logic                                 dt_out_valid,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [$clog2(CHANNELS)-1:0]          res_channel,
  output logic [$clog2(FEATURES)-1:0]          res_level,
  output logic [$clog2(FEATURES)-1:0]          res_path,
  output logic                                 res_timeout,
  output logic                                 busy
);

  localparam int CW = $clog2(CHANNELS);
  localparam int LW = $clog2(FEATURES);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int VW = FEATURES * IN_WIDTH;

  localparam logic [LW-1:0] FEAT_LAST = LW'(FEATURES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_t          state;
  logic [CW-1:0]   last_grant;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]   grant_idx;
  logic [VW-1:0]   grant_feats;
  logic [VW-1:0]   feat_q;
  logic [LW-1:0]   feat_idx;
  logic [TW-1:0]   wait_cnt;
  logic            accept;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    grant_idx   = '0;
    grant_feats = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant[c]) begin
        grant_idx   = CW'(c);
        grant_feats = req_features[c*VW +: VW];
      end
    end
  end

  // feat_q holds the features not yet driven, lowest feature in the low bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= CW'(CHANNELS - 1);
      feat_q      <= '0;
      feat_idx    <= '0;
      wait_cnt    <= '0;
      dt_sample   <= '0;
      dt_run      <= 1'b0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_level   <= '0;
      res_path    <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_FEED;
            res_channel <= grant_idx;
            dt_sample   <= grant_feats[IN_WIDTH-1:0];
            feat_q      <= grant_feats >> IN_WIDTH;
            feat_idx    <= '0;
            dt_run      <= 1'b1;
          end
        end
        ST_FEED: begin
          if (dt_out_valid) begin
            state       <= ST_HOLD;
            dt_run      <= 1'b0;
            res_valid   <= 1'b1;
            res_level   <= dt_level;
            res_path    <= dt_path;
            res_timeout <= 1'b0;
          end else if (feat_idx == FEAT_LAST) begin
            state    <= ST_WAIT;
            dt_run   <= 1'b0;
            wait_cnt <= '0;
          end else begin
            feat_idx  <= feat_idx + 1'b1;
            dt_sample <= feat_q[IN_WIDTH-1:0];
            feat_q    <= feat_q >> IN_WIDTH;
          end
        end
        ST_WAIT: begin
          if (dt_out_valid) begin
            state       <= ST_HOLD;
            res_valid   <= 1'b1;
            res_level   <= dt_level;
            res_path    <= dt_path;
            res_timeout <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ST_HOLD;
            res_valid   <= 1'b1;
            res_level   <= '0;
            res_path    <= '0;
            res_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state      <= ST_IDLE;
            res_valid  <= 1'b0;
            last_grant <= res_channel;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_channel_scheduler.sv
// Scoreboard bench for dtree_channel_scheduler with a scripted tree-datapath responder.
module tb_dtree_channel_scheduler;

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] lvl;
    logic [1:0] pth;
    logic       to;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [119:0] req_features;
  logic [9:0]   dt_sample;
  logic         dt_run;
  logic [1:0]   dt_level;
  logic [1:0]   dt_path;
  logic         dt_out_valid;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_channel;
  logic [1:0]   res_level;
  logic [1:0]   res_path;
  logic         res_timeout;
  logic         busy;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         last_ch;
  int         lat;
  logic       run_log[64];
  logic [9:0] samp_log[64];

  dtree_channel_scheduler #(
    .CHANNELS(4), .FEATURES(3), .IN_WIDTH(10), .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_features (req_features),
    .dt_sample    (dt_sample),
    .dt_run       (dt_run),
    .dt_level     (dt_level),
    .dt_path      (dt_path),
    .dt_out_valid (dt_out_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_channel  (res_channel),
    .res_level    (res_level),
    .res_path     (res_path),
    .res_timeout  (res_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One full request: grant check, datapath response at cycle resp_at after accept
  // (negative = never), optional res_ready stall, then scoreboard compare at handshake.
  task automatic do_txn(input string tag, input logic [3:0] vmask, input int resp_at,
                        input logic [1:0] lvl, input logic [1:0] pth,
                        input int hold_cycles, input int exp_lat);
    exp_t       e, got, snap;
    int         win, cyc;
    bit         seen;
    logic [3:0] exp_rdy;
    win = -1;
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last_ch + i) % 4;
      if (win < 0 && vmask[c]) win = c;
    end
    exp_rdy = 4'(1 << win);
    req_valid = vmask;
    #1;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s_grant req_ready=%b expected %b", tag, req_ready, exp_rdy);
    end
    e.ch  = 2'(win);
    e.lvl = (resp_at < 0) ? 2'd0 : lvl;
    e.pth = (resp_at < 0) ? 2'd0 : pth;
    e.to  = (resp_at < 0);
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = '0;
    cyc  = 0;
    seen = 0;
    while (cyc < 60 && !seen) begin
      run_log[cyc]  = dt_run;
      samp_log[cyc] = dt_sample;
      if (res_valid) seen = 1;
      else begin
        dt_out_valid = (cyc == resp_at);
        dt_level     = lvl;
        dt_path      = pth;
        @(posedge clk); #1;
        dt_out_valid = 1'b0;
        cyc++;
      end
    end
    lat = cyc;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_result_timeout res_valid=0 after %0d cycles, expected within %0d", tag, cyc, exp_lat);
      void'(sb.pop_front());
      return;
    end
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d cycles expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_hold busy=%b expected 1", tag, busy);
    end
    snap = {res_channel, res_level, res_path, res_timeout};
    for (int h = 0; h < hold_cycles; h++) begin
      req_valid    = 4'b1111;
      dt_out_valid = 1'b1;
      dt_level     = ~lvl;
      dt_path      = ~pth;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || res_valid !== 1'b1 ||
          {res_channel, res_level, res_path, res_timeout} !== snap) begin
        errors++;
        $display("FAIL %s_hold%0d req_ready=%b res_valid=%b res=%h expected 0000/1/%h", tag, h,
                 req_ready, res_valid, {res_channel, res_level, res_path, res_timeout}, snap);
      end
      @(posedge clk); #1;
    end
    dt_out_valid = 1'b0;
    req_valid    = '0;
    res_ready    = 1'b1;
    #1;
    got = {res_channel, res_level, res_path, res_timeout};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s_result ch=%0d lvl=%0d path=%0d to=%b expected ch=%0d lvl=%0d path=%0d to=%b",
               tag, got.ch, got.lvl, got.pth, got.to, e.ch, e.lvl, e.pth, e.to);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release res_valid=%b busy=%b expected 0 0", tag, res_valid, busy);
    end
    last_ch = win;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    dt_out_valid = 1'b0;
    dt_level = '0;
    dt_path = '0;
    for (int i = 0; i < 120; i++) req_features[i] = 1'($urandom_range(1));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
    checks++;
    if (dt_run !== 1'b0 || dt_sample !== 10'd0) begin
      errors++; $display("FAIL reset_dt got run=%b sample=%h expected 0 000", dt_run, dt_sample);
    end
    checks++;
    if (res_valid !== 1'b0 || {res_channel, res_level, res_path, res_timeout} !== 7'd0) begin
      errors++; $display("FAIL reset_res got valid=%b res=%h expected 0 00", res_valid,
                         {res_channel, res_level, res_path, res_timeout});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    reset = 1'b0;
    last_ch = 3;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < 5; n++) begin
      logic [1:0] l, p;
      l = 2'($urandom_range(3));
      p = 2'($urandom_range(3));
      do_txn($sformatf("rr%0d", n), 4'b1111, 3, l, p, 0, 4);
    end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstwait_grant got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || dt_run !== 1'b0) begin
      errors++; $display("FAIL rstwait_in_wait busy=%b dt_run=%b expected 1 0", busy, dt_run);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || dt_sample !== 10'd0) begin
      errors++; $display("FAIL rstwait_abort busy=%b res_valid=%b dt_sample=%h expected 0 0 000",
                         busy, res_valid, dt_sample);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    last_ch = 3;
    do_txn("rstwait_next", 4'b1111, 3, 2'd1, 2'd2, 0, 4);
  endtask

  task automatic test_features();
    logic [9:0] f[3];
    f[0] = 10'sd10;
    f[1] = -10'sd5;
    f[2] = 10'sd3;
    for (int k = 0; k < 3; k++) req_features[(2*3+k)*10 +: 10] = f[k];
    do_txn("feat", 4'b0100, 3, 2'd2, 2'd1, 0, 4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (samp_log[k] !== f[k] || run_log[k] !== 1'b1) begin
        errors++; $display("FAIL feat_sample%0d got %h run=%b expected %h run=1", k, samp_log[k], run_log[k], f[k]);
      end
    end
    checks++;
    if (run_log[3] !== 1'b0 || samp_log[3] !== f[2]) begin
      errors++; $display("FAIL feat_wait got run=%b sample=%h expected 0 %h", run_log[3], samp_log[3], f[2]);
    end
  endtask

  task automatic test_early_leaf();
    logic [9:0] f1;
    f1 = req_features[(3*3+1)*10 +: 10];
    do_txn("early", 4'b1111, 1, 2'd3, 2'd2, 0, 2);
    checks++;
    if (run_log[0] !== 1'b1 || run_log[1] !== 1'b1 || run_log[2] !== 1'b0) begin
      errors++; $display("FAIL early_run got %b%b%b expected 110", run_log[0], run_log[1], run_log[2]);
    end
    checks++;
    if (samp_log[1] !== f1) begin
      errors++; $display("FAIL early_sample got %h expected %h", samp_log[1], f1);
    end
  endtask

  task automatic test_timeout();
    do_txn("timeout", 4'b0011, -1, 2'd3, 2'd3, 0, 19);
  endtask

  task automatic test_back_to_back_backpressure();
    do_txn("stall", 4'b1111, 3, 2'd3, 2'd0, 5, 4);
    do_txn("b2b", 4'b1111, 3, 2'd0, 2'd3, 0, 4);
  endtask

  task automatic test_ignore_idle();
    for (int i = 0; i < 3; i++) begin
      dt_out_valid = 1'b1;
      dt_level = 2'd3;
      #1;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_dov%0d res_valid=%b busy=%b expected 0 0", i, res_valid, busy);
      end
      @(posedge clk); #1;
    end
    dt_out_valid = 1'b0;
    do_txn("after_idle_dov", 4'b1111, 3, 2'd1, 2'd1, 0, 4);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_in_wait();
    test_features();
    test_early_leaf();
    test_timeout();
    test_back_to_back_backpressure();
    test_ignore_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
